twos_complement_serial: RTL and testbench
=========================================

// Module: twos_complement_serial
// PURPOSE
//   Parametrised, multi-cycle successor to the 32-bit combinational two's-complement unit.
//   Negates a WIDTH-bit operand CHUNK bits per cycle, LSB chunk first, rippling the carry through a register.
//   Valid/ready handshakes on both sides; one operation in flight at a time.
//   Reports zero and overflow (most-negative operand) alongside the result.
//   Sits between the operand register file and the ALU result mux.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be >= 2
//   CHUNK  8   bits processed per cycle; WIDTH % CHUNK == 0 required (violation -> $error at elaboration)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand present
//   in_ready   out  1      block can accept an operand
//   operand    in   WIDTH  value to negate
//   out_valid  out  1      result, zero and overflow are valid
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  -operand, mod 2^WIDTH
//   zero       out  1      operand was 0
//   overflow   out  1      operand == 1<<(WIDTH-1); result equals operand
// BEHAVIOUR
//   - N = WIDTH/CHUNK. FSM states: IDLE, BUSY, DONE.
//   - Reset (reset==0, async): state=IDLE; result=0; zero=0; overflow=0; out_valid=0; carry=0; count=0.
//   - in_ready = (state==IDLE), combinational; reads 1 during reset. Inputs are ignored while reset==0.
//   - IDLE: on an edge with in_valid=1, accept the operand:
//       shift reg <= operand; carry <= 1; count <= 0; zero/overflow computed from operand and registered;
//       state -> BUSY.
//   - BUSY, each edge: {c, s} = ~sreg[CHUNK-1:0] + carry;
//       sreg shifts right by CHUNK with s inserted at the top; carry <= c; count <= count+1.
//       When count == N-1: state -> DONE.
//   - DONE: out_valid=1; result = sreg. Held stable until an edge with out_ready=1, then state -> IDLE.
//     out_valid=0 from that edge on. No new accept on the same edge; in_ready rises one cycle later.
//   - Latency: accept at edge k -> out_valid high after edge k+N. Throughput: one op per N+2 cycles
//     with out_ready tied high.
//   - CHUNK == WIDTH: N=1; BUSY lasts one cycle.
//   - Carry out of the final chunk is discarded (mod 2^WIDTH). It is 1 only when operand == 0.
//   - Overflow: result == operand == 0x80..0; overflow=1; zero=0.
//   - Backpressure: out_ready=0 in DONE holds all outputs indefinitely.
//   - in_valid in BUSY/DONE: ignored (in_ready=0); the producer must hold it.
//   - Reset mid-operation (BUSY or DONE): the operation is abandoned. Reset values apply immediately;
//     nothing is output afterwards.
//   - zero/overflow change only on accept and on reset, and are valid while out_valid=1.
// CONFIGURATION
//   TWOS_COMPLEMENT_ABS_EN defined:
//     - Adds input port abs_mode (1 bit), sampled at accept.
//     - abs_mode=1 and operand MSB=0: result = operand unchanged; chunks pass through uninverted and no carry is added.
//     - Latency stays N regardless.
//     - abs_mode=1 and operand MSB=1: negate as normal. Overflow is flagged as before.
//   TWOS_COMPLEMENT_ABS_EN undefined:
//     - No abs_mode port; always negate.
// TESTING  (WIDTH=32, CHUNK=8 unless noted)
//   1. operand 32'hF0000000 -> result 32'h10000000, zero=0, overflow=0; out_valid exactly 4 edges after accept.
//   2. Back-to-back 32'h20000000, 32'h00003000, 32'h00000300 with out_ready=1
//      -> 32'hE0000000, 32'hFFFFD000, 32'hFFFFFD00; each accept 6 cycles apart.
//   3. operand 0 -> result 0, zero=1; operand 32'h80000000 -> result 32'h80000000, overflow=1.
//   4. out_ready held 0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0; release -> IDLE next edge.
//   5. Assert reset 2 cycles after accepting 32'h00420000 -> out_valid/result/flags 0 at once, in_ready=1.
//      Release reset; 32'h00013000 -> 32'hFFFED000.
//   6. With ABS_EN: abs_mode=1, 32'h00013000 -> 32'h00013000; abs_mode=1, 32'hFFFFFD00 -> 32'h00000300.
//      With CHUNK=32: 32'h10000000 -> 32'hF0000000 after 1 edge.

Source files
------------

// File: rtl/twos_complement_serial.sv
// ---------------------------------------------------------------------------
// twos_complement_serial
//   Multi-cycle two's-complement negation unit. A WIDTH-bit operand is
//   negated CHUNK bits per cycle, least-significant chunk first. The carry
//   ripples between chunks through a register. Valid/ready handshakes are
//   used on both sides, and only one operation is in flight at a time.
//   The unit reports zero and overflow (most-negative operand) alongside the
//   result.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   CHUNK  bits processed per cycle (WIDTH % CHUNK == 0)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   in_valid   in   operand present
//   in_ready   out  block can accept an operand (high in IDLE)
//   operand    in   value to negate
//   abs_mode   in   (only with TWOS_COMPLEMENT_ABS_EN) absolute-value request
//   out_valid  out  result, zero and overflow are valid
//   out_ready  in   consumer takes the result
//   result     out  -operand mod 2^WIDTH (or |operand| in abs mode)
//   zero       out  operand was 0
//   overflow   out  operand was the most-negative value
//
// Configuration macro
//   TWOS_COMPLEMENT_ABS_EN  adds abs_mode. A non-negative operand then passes
//                           through unchanged with the same latency.
// ---------------------------------------------------------------------------
module twos_complement_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
`ifdef TWOS_COMPLEMENT_ABS_EN
    input  logic             abs_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
            $error("twos_complement_serial: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    // Operand classification helpers, evaluated once at accept time.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    function automatic logic is_most_neg(input logic [WIDTH-1:0] v);
        return (v == {1'b1, {(WIDTH-1){1'b0}}});
    endfunction

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] sreg_q,     sreg_d;
    logic             carry_q,    carry_d;
    logic [CW-1:0]    count_q,    count_d;
    logic             zero_q,     zero_d;
    logic             overflow_q, overflow_d;

    // Pass-through flag: set when abs mode sees a non-negative operand.
    logic             pass_s;
`ifdef TWOS_COMPLEMENT_ABS_EN
    logic             pass_q, pass_d;
    assign pass_s = pass_q;
`else
    assign pass_s = 1'b0;
`endif

    logic [CHUNK-1:0] chunk_s;
    logic             carry_add_s;
    logic [CHUNK:0]   sum_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] insert_s;

    // Per-chunk datapath: inverted low chunk plus rippled carry (or raw pass-through).
    always_comb begin
        chunk_s     = {CHUNK{1'b0}};
        carry_add_s = 1'b0;
        if (pass_s) begin
            chunk_s     = sreg_q[CHUNK-1:0];
            carry_add_s = 1'b0;
        end else begin
            chunk_s     = ~sreg_q[CHUNK-1:0];
            carry_add_s = carry_q;
        end
        sum_s     = {1'b0, chunk_s} + {{CHUNK{1'b0}}, carry_add_s};
        // The shift by CHUNK also covers CHUNK == WIDTH, where it yields all zeros.
        shifted_s = sreg_q >> CHUNK;
        insert_s  = WIDTH'(sum_s[CHUNK-1:0]) << (WIDTH - CHUNK);
    end

    // Next-state logic for the IDLE/BUSY/DONE sequencer and its datapath registers.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        carry_d    = carry_q;
        count_d    = count_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
`ifdef TWOS_COMPLEMENT_ABS_EN
        pass_d     = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sreg_d     = operand;
                    carry_d    = 1'b1;
                    count_d    = {CW{1'b0}};
                    zero_d     = is_zero(operand);
                    overflow_d = is_most_neg(operand);
`ifdef TWOS_COMPLEMENT_ABS_EN
                    pass_d     = abs_mode & ~operand[WIDTH-1];
`endif
                    state_d    = ST_BUSY;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BUSY: begin
                sreg_d  = shifted_s | insert_s;
                // The carry out of the final chunk is dropped with the next accept.
                carry_d = sum_s[CHUNK];
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sreg_q     <= {WIDTH{1'b0}};
            carry_q    <= 1'b0;
            count_q    <= {CW{1'b0}};
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef TWOS_COMPLEMENT_ABS_EN
            pass_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            carry_q    <= carry_d;
            count_q    <= count_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
`ifdef TWOS_COMPLEMENT_ABS_EN
            pass_q     <= pass_d;
`endif
        end
    end

    // Outputs come straight from flops. in_ready reads 1 during reset because state is IDLE.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = sreg_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_twos_complement_serial.sv
module tb_twos_complement_serial;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         in_valid,  in_ready,  out_valid, out_ready, zero, overflow;
    logic [W-1:0] operand,   result;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, zero1, overflow1;
    logic [W-1:0] operand1,  result1;
`ifdef TWOS_COMPLEMENT_ABS_EN
    logic         abs_mode, abs_mode1;
`endif

    int vectors;
    int miscompares;
    int cyc;

    twos_complement_serial #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .operand(operand),
`ifdef TWOS_COMPLEMENT_ABS_EN
        .abs_mode(abs_mode),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .overflow(overflow)
    );

    twos_complement_serial #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .operand(operand1),
`ifdef TWOS_COMPLEMENT_ABS_EN
        .abs_mode(abs_mode1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
        .zero(zero1), .overflow(overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one operation on dut: wait for in_ready, accept, then wait for out_valid.
    task automatic do_op(input logic [W-1:0] op, input logic abs_m,
                         output logic [W-1:0] res, output logic z, output logic ov,
                         output int acc_cyc, output int lat);
        int budget;
`ifdef TWOS_COMPLEMENT_ABS_EN
        abs_mode = abs_m;
`else
        if (abs_m) begin
            $display("abs_mode request ignored in this build");
        end else begin
        end
`endif
        operand  = op;
        in_valid = 1'b1;
        budget   = 20;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("timeout_in_ready", 64'd0, 64'd1);
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat      = 0;
        budget   = 20;
        while (!out_valid && budget > 0) begin
            tick();
            lat++;
            budget--;
        end
        if (budget == 0) check("timeout_out_valid", 64'd0, 64'd1);
        res = result;
        z   = zero;
        ov  = overflow;
    endtask

    logic [W-1:0] r;
    logic         z, ov;
    int           acc, lat, prev_acc;
    logic [W-1:0] held;

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        operand     = 32'h0;
        in_valid1   = 1'b0;
        out_ready1  = 1'b1;
        operand1    = 32'h0;
`ifdef TWOS_COMPLEMENT_ABS_EN
        abs_mode    = 1'b0;
        abs_mode1   = 1'b0;
`endif
        #3;
        // Reset state
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_zero",      64'(zero),      64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 1: single op with latency check, out_ready low
        operand  = 32'hF0000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t1_early_valid", 64'(out_valid), 64'd0);
        end
        tick();
        check("t1_valid",    64'(out_valid), 64'd1);
        check("t1_result",   64'(result),    64'h10000000);
        check("t1_zero",     64'(zero),      64'd0);
        check("t1_overflow", 64'(overflow),  64'd0);
        out_ready = 1'b1;
        tick();
        check("t1_drop_valid", 64'(out_valid), 64'd0);
        check("t1_in_ready",   64'(in_ready),  64'd1);

        // 2: back-to-back with out_ready held high
        do_op(32'h20000000, 1'b0, r, z, ov, acc, lat);
        check("t2a_result",  64'(r),   64'hE0000000);
        check("t2a_latency", 64'(lat), 64'd4);
        prev_acc = acc;
        do_op(32'h00003000, 1'b0, r, z, ov, acc, lat);
        check("t2b_result",  64'(r),              64'hFFFFD000);
        check("t2b_spacing", 64'(acc - prev_acc), 64'd6);
        prev_acc = acc;
        do_op(32'h00000300, 1'b0, r, z, ov, acc, lat);
        check("t2c_result",  64'(r),              64'hFFFFFD00);
        check("t2c_spacing", 64'(acc - prev_acc), 64'd6);

        // 3: zero and most-negative operands
        do_op(32'h00000000, 1'b0, r, z, ov, acc, lat);
        check("t3_zero_result", 64'(r),  64'h0);
        check("t3_zero_flag",   64'(z),  64'd1);
        check("t3_zero_ovf",    64'(ov), 64'd0);
        do_op(32'h80000000, 1'b0, r, z, ov, acc, lat);
        check("t3_ovf_result", 64'(r),  64'h80000000);
        check("t3_ovf_flag",   64'(ov), 64'd1);
        check("t3_ovf_zero",   64'(z),  64'd0);

        // 4: backpressure for 5 cycles
        tick();
        out_ready = 1'b0;
        do_op(32'h00000300, 1'b0, r, z, ov, acc, lat);
        held = r;
        check("t4_result", 64'(held), 64'hFFFFFD00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid",  64'(out_valid), 64'd1);
            check("t4_hold_result", 64'(result),    64'(held));
            check("t4_hold_ready",  64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        tick();
        check("t4_release_valid", 64'(out_valid), 64'd0);
        check("t4_release_ready", 64'(in_ready),  64'd1);

        // 5: reset two cycles after accept
        operand  = 32'h00420000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t5_busy_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t5_rst_valid",    64'(out_valid), 64'd0);
        check("t5_rst_result",   64'(result),    64'd0);
        check("t5_rst_zero",     64'(zero),      64'd0);
        check("t5_rst_overflow", 64'(overflow),  64'd0);
        check("t5_rst_ready",    64'(in_ready),  64'd1);
        tick();
        reset = 1'b1;
        tick();
        do_op(32'h00013000, 1'b0, r, z, ov, acc, lat);
        check("t5_after_result", 64'(r), 64'hFFFED000);

`ifdef TWOS_COMPLEMENT_ABS_EN
        // 6a: absolute-value mode
        do_op(32'h00013000, 1'b1, r, z, ov, acc, lat);
        check("t6_abs_pos",     64'(r),   64'h00013000);
        check("t6_abs_pos_lat", 64'(lat), 64'd4);
        do_op(32'hFFFFFD00, 1'b1, r, z, ov, acc, lat);
        check("t6_abs_neg",     64'(r),   64'h00000300);
        do_op(32'h80000000, 1'b1, r, z, ov, acc, lat);
        check("t6_abs_ovf",     64'(ov),  64'd1);
        abs_mode = 1'b0;
`endif

        // 6b: CHUNK == WIDTH, single BUSY cycle
        operand1  = 32'h10000000;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check("t6_c32_busy",   64'(out_valid1), 64'd0);
        tick();
        check("t6_c32_valid",  64'(out_valid1), 64'd1);
        check("t6_c32_result", 64'(result1),    64'hF0000000);
        tick();
        check("t6_c32_idle",   64'(in_ready1),  64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
